// File: rtl/mac_rx_pkg.sv
// mac_rx_pkg: shared byte codes, state encoding and status bit indices for the receive framer
package mac_rx_pkg;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  typedef enum logic [1:0] {RX_IDLE, RX_PRE, RX_DATA, RX_DROP} rx_state_e;
  localparam int STAT_PHYERR = 0;
  localparam int STAT_SHORT = 1;
  localparam int STAT_LONG = 2;
endpackage

// File: rtl/mac_rx_framer.sv
// mac_rx_framer: strips preamble/SFD and delivers payload with sof/eof, length, status and drop pulses
module mac_rx_framer
  import mac_rx_pkg::*;
#(
  parameter int MIN_PREAMBLE = 1,
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic        MAC_rx_clk,
  input  logic        Reset,
  input  logic        MCrs_dv,
  input  logic [7:0]  MRxD,
  input  logic        MRxErr,
  output logic [7:0]  Rx_data,
  output logic        Rx_valid,
  output logic        Rx_sof,
  output logic        Rx_eof,
  output logic [15:0] Rx_len,
  output logic [2:0]  Rx_stat,
  output logic        Rx_drop
);
  rx_state_e state, state_n;
  logic [2:0] pre_cnt, pre_cnt_n;
  logic [15:0] len, len_n, len_o_n;
  logic err, err_n, full, full_n, first, first_n, start;
  logic [7:0] hold, hold_n, data_n;
  logic valid_n, sof_n, eof_n, drop_n;
  logic [2:0] stat_n;
  always_ff @(posedge MAC_rx_clk or posedge Reset)
    if (Reset) begin
      state <= RX_IDLE;
      pre_cnt <= '0;
      len <= '0;
      err <= 1'b0;
      full <= 1'b0;
      first <= 1'b0;
      hold <= '0;
      Rx_data <= '0;
      Rx_valid <= 1'b0;
      Rx_sof <= 1'b0;
      Rx_eof <= 1'b0;
      Rx_len <= '0;
      Rx_stat <= '0;
      Rx_drop <= 1'b0;
    end else begin
      state <= state_n;
      pre_cnt <= pre_cnt_n;
      len <= len_n;
      err <= err_n;
      full <= full_n;
      first <= first_n;
      hold <= hold_n;
      Rx_data <= data_n;
      Rx_valid <= valid_n;
      Rx_sof <= sof_n;
      Rx_eof <= eof_n;
      Rx_len <= len_o_n;
      Rx_stat <= stat_n;
      Rx_drop <= drop_n;
    end
  always_comb begin
    state_n = state;
    pre_cnt_n = pre_cnt;
    len_n = len;
    err_n = err;
    full_n = full;
    first_n = first;
    hold_n = hold;
    data_n = Rx_data;
    valid_n = 1'b0;
    sof_n = 1'b0;
    eof_n = 1'b0;
    len_o_n = '0;
    stat_n = '0;
    drop_n = 1'b0;
    start = 1'b0;
    case (state)
      RX_IDLE:
        if (MCrs_dv) begin
          if (!MRxErr && MRxD == PREAMBLE_BYTE) begin
            state_n = RX_PRE;
            pre_cnt_n = 3'd1;
          end else if (!MRxErr && MRxD == SFD_BYTE && MIN_PREAMBLE == 0) start = 1'b1;
          else begin
            state_n = RX_DROP;
            drop_n = 1'b1;
          end
        end
      RX_PRE:
        if (!MCrs_dv) begin
          state_n = RX_IDLE;
          drop_n = 1'b1;
        end else if (!MRxErr && MRxD == PREAMBLE_BYTE) pre_cnt_n = &pre_cnt ? pre_cnt : pre_cnt + 3'd1;
        else if (!MRxErr && MRxD == SFD_BYTE && int'(pre_cnt) >= MIN_PREAMBLE) start = 1'b1;
        else begin
          state_n = RX_DROP;
          drop_n = 1'b1;
        end
      RX_DATA:
        // one-byte hold delays output by a cycle so the last byte can carry eof
        if (MCrs_dv) begin
          hold_n = MRxD;
          full_n = 1'b1;
          len_n = &len ? len : len + 16'd1;
          err_n = err | MRxErr;
          valid_n = full;
          sof_n = full & first;
          first_n = first & ~full;
          data_n = full ? hold : Rx_data;
        end else begin
          state_n = RX_IDLE;
          full_n = 1'b0;
          valid_n = full;
          sof_n = full & first;
          eof_n = full;
          data_n = full ? hold : Rx_data;
          len_o_n = full ? len : '0;
          stat_n[STAT_PHYERR] = full & err;
          stat_n[STAT_SHORT] = full & (int'(len) < MIN_FRAME);
          stat_n[STAT_LONG] = full & (int'(len) > MAX_FRAME);
          drop_n = ~full;
        end
      default:
        if (!MCrs_dv) state_n = RX_IDLE;
    endcase
    if (start) begin
      state_n = RX_DATA;
      len_n = '0;
      err_n = 1'b0;
      full_n = 1'b0;
      first_n = 1'b1;
    end
  end
endmodule

// File: tb/tb_mac_rx_framer.sv
// tb_mac_rx_framer: randomized frames scored cycle-by-cycle against an expectation timeline built from the framing rules
module tb_mac_rx_framer;
  localparam int MINP = 3;
  localparam int MIN_FRAME = 64;
  localparam int MAX_FRAME = 1518;
  localparam int N = 16384;
  logic clk = 1'b0, Reset, MCrs_dv, MRxErr;
  logic [7:0] MRxD, Rx_data;
  logic Rx_valid, Rx_sof, Rx_eof, Rx_drop;
  logic [15:0] Rx_len;
  logic [2:0] Rx_stat;
  int cyc = 0, errors = 0, checks = 0;
  bit ev[N], es[N], ee[N], ed[N], lit_on[N];
  bit [7:0] edat[N];
  bit [15:0] el[N], lit_l[N];
  bit [2:0] est[N], lit_s[N];
  logic [7:0] last = 8'h00;

  mac_rx_framer #(.MIN_PREAMBLE(MINP), .MIN_FRAME(MIN_FRAME), .MAX_FRAME(MAX_FRAME)) dut (
    .MAC_rx_clk(clk), .Reset(Reset), .MCrs_dv(MCrs_dv), .MRxD(MRxD), .MRxErr(MRxErr),
    .Rx_data(Rx_data), .Rx_valid(Rx_valid), .Rx_sof(Rx_sof), .Rx_eof(Rx_eof),
    .Rx_len(Rx_len), .Rx_stat(Rx_stat), .Rx_drop(Rx_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // expectation index k = outputs seen after posedge k; byte sampled at edge k is due at k+1
  always @(negedge clk) begin
    if (Reset) begin
      last = 8'h00;
      checks++;
      if ({Rx_valid, Rx_sof, Rx_eof, Rx_drop, Rx_data, Rx_len, Rx_stat} !== '0) begin
        errors++;
        $display("FAIL reset_out cyc=%0d got v%b s%b e%b d%b data=%h len=%0d stat=%b want all zero",
                 cyc, Rx_valid, Rx_sof, Rx_eof, Rx_drop, Rx_data, Rx_len, Rx_stat);
      end
    end else if (cyc < N) begin
      if (ev[cyc]) last = edat[cyc];
      checks++;
      if (Rx_valid !== ev[cyc] || Rx_sof !== es[cyc] || Rx_eof !== ee[cyc] || Rx_drop !== ed[cyc] ||
          Rx_data !== last || (ee[cyc] && (Rx_len !== el[cyc] || Rx_stat !== est[cyc]))) begin
        errors++;
        $display("FAIL stream cyc=%0d got v%b s%b e%b d%b data=%h len=%0d stat=%b want v%b s%b e%b d%b data=%h len=%0d stat=%b",
                 cyc, Rx_valid, Rx_sof, Rx_eof, Rx_drop, Rx_data, Rx_len, Rx_stat,
                 ev[cyc], es[cyc], ee[cyc], ed[cyc], last, el[cyc], est[cyc]);
      end
      if (lit_on[cyc]) begin
        checks++;
        if (Rx_eof !== 1'b1 || Rx_len !== lit_l[cyc] || Rx_stat !== lit_s[cyc]) begin
          errors++;
          $display("FAIL eof_literal cyc=%0d got eof=%b len=%0d stat=%b want eof=1 len=%0d stat=%b",
                   cyc, Rx_eof, Rx_len, Rx_stat, lit_l[cyc], lit_s[cyc]);
        end
      end
    end
  end

  task automatic step(input logic dv, input logic [7:0] d, input logic er);
    MCrs_dv = dv;
    MRxD = d;
    MRxErr = er;
    @(negedge clk);
  endtask

  task automatic good_frame(input int npre, input int n, input int errpos, input bit inc,
                            input byte unsigned first_byte, input int gap, input int lit_len, input int lit_stat);
    bit any_err = 1'b0, er;
    byte unsigned b;
    int e;
    for (int i = 0; i < npre; i++) step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'hD5, 1'b0);
    for (int j = 0; j < n; j++) begin
      b = inc ? 8'(int'(first_byte) + j) : 8'($urandom);
      er = (errpos == -2) ? ($urandom_range(0, 19) == 0) : (j == errpos);
      any_err |= er;
      e = cyc + 2;
      if (e < N) begin
        ev[e] = 1'b1;
        edat[e] = b;
        es[e] = (j == 0);
        if (j == n - 1) begin
          ee[e] = 1'b1;
          el[e] = 16'(n);
          est[e] = {n > MAX_FRAME, n < MIN_FRAME, any_err};
          if (lit_len >= 0) begin
            lit_on[e] = 1'b1;
            lit_l[e] = 16'(lit_len);
            lit_s[e] = 3'(lit_stat);
          end
        end
      end
      step(1'b1, b, er);
    end
    for (int g = 0; g < gap; g++) step(1'b0, 8'($urandom), 1'b0);
  endtask

  // kinds: 0 bad byte, 1 PHY error, 2 early SFD, 3 carrier lost in preamble, 4 carrier lost right after SFD
  task automatic bad_frame(input int kind, input int k, input int extra, input int gap);
    byte unsigned b;
    for (int i = 0; i < k; i++) step(1'b1, 8'h55, 1'b0);
    if (cyc + 1 < N) ed[cyc + 1] = (kind != 4);
    case (kind)
      0: begin
        do b = 8'($urandom); while (b == 8'h55 || b == 8'hD5);
        step(1'b1, b, 1'b0);
      end
      1: step(1'b1, 8'($urandom), 1'b1);
      2: step(1'b1, 8'hD5, 1'b0);
      3: step(1'b0, 8'($urandom), 1'b0);
      default: begin
        step(1'b1, 8'hD5, 1'b0);
        if (cyc + 1 < N) ed[cyc + 1] = 1'b1;
        step(1'b0, 8'($urandom), 1'b0);
      end
    endcase
    if (kind < 3) begin
      for (int i = 0; i < extra; i++) step(1'b1, 8'($urandom), 1'($urandom));
      step(1'b0, 8'($urandom), 1'b0);
    end
    for (int g = 1; g < gap; g++) step(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic reset_mid();
    int e;
    for (int i = 0; i < 7; i++) step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'hD5, 1'b0);
    for (int j = 0; j < 20; j++) begin
      if (j < 19) begin
        e = cyc + 2;
        ev[e] = 1'b1;
        edat[e] = 8'(j + 1);
        es[e] = (j == 0);
      end
      step(1'b1, 8'(j + 1), 1'b0);
    end
    MRxD = 8'h21;
    #2 Reset = 1'b1;
    @(negedge clk);
    MRxD = 8'h22;
    @(negedge clk);
    #2 Reset = 1'b0;
    ed[cyc + 1] = 1'b1;
    MRxD = 8'h23;
    @(negedge clk);
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'($urandom));
    step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int kind, k;
    Reset = 1'b1;
    MCrs_dv = 1'b0;
    MRxD = 8'h00;
    MRxErr = 1'b0;
    repeat (3) @(negedge clk);
    #2 Reset = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    good_frame(7, 64, -1, 1'b1, 8'h00, 1, 64, 0);
    good_frame(7, 10, 5, 1'b0, 8'h00, 2, 10, 3);
    bad_frame(0, 1, 3, 1);
    good_frame(7, 20, -1, 1'b0, 8'h00, 1, 20, 2);
    good_frame(7, 1520, -1, 1'b0, 8'h00, 1, 1520, 4);
    good_frame(7, 1, -1, 1'b1, 8'h5A, 1, 1, 2);
    good_frame(7, 1518, -1, 1'b0, 8'h00, 1, 1518, 0);
    good_frame(7, 1519, 0, 1'b0, 8'h00, 1, 1519, 5);
    good_frame(7, 63, -1, 1'b0, 8'h00, 1, 63, 2);
    reset_mid();
    good_frame(7, 30, -1, 1'b0, 8'h00, 2, 30, 2);
    bad_frame(2, 2, 2, 1);
    good_frame(3, 70, -1, 1'b0, 8'h00, 1, 70, 0);
    good_frame(12, 5, -1, 1'b0, 8'h00, 1, 5, 2);
    bad_frame(3, 4, 0, 1);
    bad_frame(4, 5, 0, 1);
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 9) < 5)
        good_frame($urandom_range(MINP, 12), $urandom_range(1, 90), -2, 1'b0, 8'h00,
                   $urandom_range(1, 3), -1, 0);
      else begin
        kind = $urandom_range(0, 4);
        k = (kind == 2) ? $urandom_range(0, MINP - 1) : (kind == 3) ? $urandom_range(1, 7) :
            (kind == 4) ? $urandom_range(MINP, 7) : $urandom_range(0, 7);
        bad_frame(kind, k, $urandom_range(0, 4), $urandom_range(1, 3));
      end
    end
    repeat (4) step(1'b0, 8'h00, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
